// File: rtl/result_mem_reader.sv
// result_mem_reader: drains result records from the shared result BRAM and
// streams each one MSB-first, byte by byte, to the UART transmitter. It
// pulses doneTransmitting when the drain completes.
// Optional feature macro: MEMREADER_CHECKSUM_EN appends an XOR checksum byte
// after the data bytes of every record.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; numRecords captured on acceptance
// READ   | enA asserted, addrA = current record index
// WAIT   | BRAM data valid this cycle, captured into the shift register
// SEND   | presenting record bytes, top byte first, one per transfer
// CKSUM  | presenting the XOR of the record's bytes (checksum build only)
// DONE   | one-cycle doneTransmitting pulse, then back to IDLE
module result_mem_reader #(
  parameter int ADDR_W = 11,
  parameter int REC_W  = 192
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   numRecords,
  output logic              enA,
  output logic [ADDR_W-1:0] addrA,
  input  logic [REC_W-1:0]  doutA,
  output logic [7:0]        txData,
  output logic              txValid,
  input  logic              txReady,
  output logic              busy,
  output logic              doneTransmitting
);

  localparam int NB   = REC_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
`ifdef MEMREADER_CHECKSUM_EN
    S_CKSUM = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [REC_W-1:0]  shift_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [7:0]        top_byte;
  logic              more_records;
  logic              rec_done;
  logic              data_xfer;

`ifdef MEMREADER_CHECKSUM_EN
  logic [7:0]        cksum_q;
`endif

  assign idx_inc      = idx_q + IDX_ONE;
  assign more_records = (idx_inc < count_q);
  assign top_byte     = shift_q[REC_W-1 -: 8];
  assign addrA        = addr_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and outputs; rec_done marks the last transfer of a record
  always_comb begin
    state_d          = state_q;
    enA              = 1'b0;
    txValid          = 1'b0;
    txData           = top_byte;
    doneTransmitting = 1'b0;
    busy             = (state_q != S_IDLE);
    rec_done         = 1'b0;
    data_xfer        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (numRecords == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        enA     = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        txValid   = 1'b1;
        data_xfer = txReady;
        if (txReady && (byte_cnt_q == LAST_BYTE)) begin
`ifdef MEMREADER_CHECKSUM_EN
          state_d = S_CKSUM;
`else
          rec_done = 1'b1;
          state_d  = more_records ? S_READ : S_DONE;
`endif
        end
      end
`ifdef MEMREADER_CHECKSUM_EN
      S_CKSUM: begin
        txValid = 1'b1;
        txData  = cksum_q;
        if (txReady) begin
          rec_done = 1'b1;
          state_d  = more_records ? S_READ : S_DONE;
        end
      end
`endif
      S_DONE: begin
        doneTransmitting = 1'b1;
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Count capture, record indexing, address register and byte shifter
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        count_q <= (numRecords > DEPTH) ? DEPTH : numRecords;
        idx_q   <= '0;
        addr_q  <= '0;
      end
      if (state_q == S_WAIT) begin
        shift_q    <= doutA;
        byte_cnt_q <= '0;
      end
      if (data_xfer) begin
        shift_q    <= {shift_q[REC_W-9:0], 8'h00};
        byte_cnt_q <= byte_cnt_q + BC_ONE;
      end
      // addrA is loaded only when heading into READ, so it holds otherwise
      if (rec_done && more_records) begin
        idx_q  <= idx_inc;
        addr_q <= idx_inc[ADDR_W-1:0];
      end
    end
  end

`ifdef MEMREADER_CHECKSUM_EN
  // Running XOR of the data bytes of the current record
  always_ff @(posedge clock) begin
    if (reset) begin
      cksum_q <= '0;
    end else if (state_q == S_WAIT) begin
      cksum_q <= '0;
    end else if (data_xfer) begin
      cksum_q <= cksum_q ^ top_byte;
    end
  end
`endif

endmodule

// File: doc/result_mem_reader.md
# result_mem_reader

Reads Black-Scholes result records back out of the shared 2048-deep × 192-bit result BRAM and streams them byte-by-byte to the UART transmit path. It is the read-side counterpart of the result memory writer: the writer fills the BRAM during a compute round, and this block drains it on command. When the block finishes, it pulses the done-transmitting signal, which starts the next round.

## Interface
- `ADDR_W`, 11: BRAM address width. Depth is 2^ADDR_W records.
- `REC_W`, 192: record width in bits. Must be a multiple of 8; bytes per record NB = REC_W/8 (24).
- `clock` in 1: single system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high. Returns every register to its reset value.
- `start` in 1: one-cycle request to begin a drain. Sampled only in IDLE.
- `numRecords` in ADDR_W+1: number of records to send, 0..2048. Captured when `start` is accepted.
- `enA` out 1: BRAM read enable.
- `addrA` out ADDR_W: BRAM read address.
- `doutA` in REC_W: BRAM read data. Valid exactly 1 cycle after `enA`.
- `txData` out 8: byte to the UART transmitter.
- `txValid` out 1: `txData` is valid.
- `txReady` in 1: transmitter accepts the byte. A transfer happens on a cycle where `txValid && txReady`.
- `busy` out 1: a drain is in progress.
- `doneTransmitting` out 1: one-cycle pulse at the end of a drain.

## Operation
- States: IDLE, READ, WAIT, SEND, CKSUM (macro only), DONE.
- IDLE:
  - `start=1` and `numRecords=0` goes to DONE.
  - `start=1` and `numRecords>0` latches the count, clears the record index, and goes to READ.
- READ:
  - Drives `enA=1` and `addrA` = record index. Goes to WAIT.
- WAIT:
  - `doutA` is valid in this cycle. It is captured into a REC_W shift register at the end of the cycle.
  - Clears the byte counter. Goes to SEND.
- SEND:
  - `txValid=1`. `txData` is the current top byte; byte 0 is `doutA[REC_W-1:REC_W-8]`, so bytes go out MSB first.
  - On each transfer: shift left by 8 and increment the byte counter.
  - The transfer of byte NB-1 goes to CKSUM if the macro is defined, otherwise to the next-record step.
- Next-record step:
  - If index+1 < count: increment the index and go to READ.
  - Otherwise go to DONE.
- DONE:
  - `doneTransmitting=1` for exactly this cycle. Next state is IDLE.
- `busy`=1 in every state except IDLE.
- While `txValid=1` and `txReady=0`, `txData` must hold stable. No byte is dropped and no byte is duplicated.
- `start` while busy is ignored.
- `numRecords` changes after acceptance have no effect on the drain in progress.
- `numRecords` greater than 2048 is saturated to 2048.
- The record index never wraps within a drain; the last address is count-1.
- `enA` is asserted only in READ. `addrA` holds its last value otherwise.
- `reset` asserted mid-drain, including during SEND with a byte pending:
  - At the next edge, state is IDLE and all outputs are at reset values.
  - No `doneTransmitting` pulse is produced.
  - The next `start` begins again from address 0.
- Reset values: `enA=0`, `addrA=0`, `txData=0`, `txValid=0`, `busy=0`, `doneTransmitting=0`. State is IDLE and all counters are 0.

## Timing
- `start` sampled at edge E0:
  - READ (`enA=1`) during cycle E0+1.
  - WAIT during E0+2.
  - First `txValid` during E0+3.
- Gap between records: after the last transfer of a record (last data byte, or checksum byte if enabled) at edge T:
  - READ in T+1, WAIT in T+2, next record's byte 0 valid in T+3.
- With `txReady` held at 1, one record takes NB+2 cycles (NB+3 with the checksum).
- End of drain: final transfer at edge T gives `doneTransmitting` in cycle T+1. `busy` is still 1 in that cycle and 0 in T+2.
- `numRecords=0`: `start` at E0 gives `doneTransmitting` in E0+1. No `enA` and no `txValid`.
- Earliest re-start is the cycle `busy` reads 0.

## Configuration
- `MEMREADER_CHECKSUM_EN` defined:
  - After the NB data bytes of each record, CKSUM presents one extra byte: the XOR of those NB bytes.
  - CKSUM holds `txValid` under backpressure and behaves like SEND.
  - 25 bytes per record.
- Not defined:
  - The CKSUM state and the XOR accumulator do not exist.
  - 24 bytes per record.

## Test plan
- Single record, `doutA` = 0x0102…18, `txReady`=1:
  - Bytes 0x01..0x18 in order.
  - First `txValid` 3 cycles after `start`.
  - `doneTransmitting` high for 1 cycle, the cycle after the 0x18 transfer.
- `numRecords`=3 with distinct records:
  - `addrA` = 0, 1, 2; 72 bytes total.
  - 2-cycle `txValid` gap between records.
  - Exactly one done pulse.
- Backpressure, `txReady` toggling 1/0 plus random stalls on 2 records:
  - `txData` stable whenever `txValid && !txReady`.
  - Byte stream identical to the no-stall run.
- `numRecords`=0:
  - Done pulse 1 cycle after `start`.
  - `enA` and `txValid` never asserted.
  - `start` pulses while busy on a 2-record drain are ignored.
- `reset` during byte 10 of record 1:
  - Next cycle: `txValid`=0, `busy`=0, no done pulse.
  - A subsequent `start` reads `addrA`=0 first.
- `MEMREADER_CHECKSUM_EN`, record 0x0102…18:
  - 25th byte is 0x18 (the XOR of 0x01..0x18).
  - Done pulse follows that byte.
